// File: rtl/alu_seq_pkg.sv
// Purpose : shared constants and state type for the multi-cycle ALU sequencer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents:
//   W_DEF                      default operand width (must equal the ALU width)
//   ALUC_ADD/ALUC_SUB/ALUC_OR  opcodes understood by the shared ALU
//   state_t                    sequencer state encoding
package alu_seq_pkg;

    localparam int W_DEF = 32;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_CHK  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Purpose : bus between the sequencer and the shared single-cycle ALU.
// Latency : combinational; the ALU answers within the same cycle.
// Backpr. : none; the sequencer simply owns the ALU while alu_own is high.
//
// Signals:
//   alu_own   sequencer -> datapath  mux select, 1 = sequencer drives the ALU
//   alu_a     sequencer -> ALU       operand a
//   alu_b     sequencer -> ALU       operand b
//   alu_aluc  sequencer -> ALU       opcode (ALUC_* in alu_seq_pkg)
//   alu_s     ALU -> sequencer       result
//   alu_z     ALU -> sequencer       zero flag (alu_s == 0)
// Modports: master = sequencer side, slave = ALU / datapath side.
interface alu_seq_ctrl_if
    import alu_seq_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         alu_own;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_aluc;
    logic [W-1:0] alu_s;
    logic         alu_z;

    modport master (
        output alu_own,
        output alu_a,
        output alu_b,
        output alu_aluc,
        input  alu_s,
        input  alu_z
    );

    modport slave (
        input  alu_own,
        input  alu_a,
        input  alu_b,
        input  alu_aluc,
        output alu_s,
        output alu_z
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Purpose : multi-cycle unsigned multiply (shift-add) / divide (restoring) on a borrowed ALU.
// Latency : MUL done k+33, DIV done k+34, divide-by-zero done k+2 (start accepted at edge k).
// Backpr. : none; start is only sampled in IDLE, requests while busy or in DONE are dropped.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, op           request and operation (0 = MUL, 1 = DIV)
//   opa, opb            multiplicand/dividend, multiplier/divisor
//   alu                 alu_seq_ctrl_if.master: operands/opcode out, result/zero flag in
//   busy, done          busy in MUL/CHK/DIV, one-cycle done pulse
//   hi, lo, dz          MUL: product high/low; DIV: remainder/quotient; divide-by-zero flag
// Configuration: macro ALU_SEQ_DIV_EN enables CHK/DIV states and dz. Without it every
// request is a multiply and dz is tied 0.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = $clog2(W)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [W-1:0]         opa,
    input  logic [W-1:0]         opb,
    alu_seq_ctrl_if.master       alu,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         hi,
    output logic [W-1:0]         lo,
    output logic                 dz
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t         state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    // mcand holds the multiplicand during MUL and the divisor during DIV.
    logic [W-1:0]   mcand, mcand_n;
    logic [W-1:0]   hi_q, hi_n;
    logic [W-1:0]   lo_q, lo_n;
    logic           carry;

`ifdef ALU_SEQ_DIV_EN
    logic           dz_q, dz_n;
    logic [W-1:0]   rem_t;
    logic           quo_bit;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcand <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
            dz_q  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mcand <= mcand_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
`ifdef ALU_SEQ_DIV_EN
            dz_q  <= dz_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state, datapath update and ALU drive
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        mcand_n      = mcand;
        hi_n         = hi_q;
        lo_n         = lo_q;
        carry        = 1'b0;
        alu.alu_a    = '0;
        alu.alu_b    = '0;
        alu.alu_aluc = ALUC_ADD;
`ifdef ALU_SEQ_DIV_EN
        dz_n         = dz_q;
        rem_t        = '0;
        quo_bit      = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    mcand_n = opa;
                    hi_n    = '0;
                    lo_n    = opb;
                    cnt_n   = '0;
`ifdef ALU_SEQ_DIV_EN
                    dz_n    = 1'b0;
                    state_n = op ? ST_CHK : ST_MUL;
`else
                    state_n = ST_MUL;
`endif
                end
            end

            ST_MUL: begin
                alu.alu_a    = hi_q;
                alu.alu_b    = mcand;
                alu.alu_aluc = ALUC_ADD;
                // The ALU has no carry-out; an unsigned add wrapped iff the sum is below an operand.
                carry = (alu.alu_s < hi_q);
                if (lo_q[0]) begin
                    {hi_n, lo_n} = {carry, alu.alu_s, lo_q[W-1:1]};
                end else begin
                    {hi_n, lo_n} = {1'b0, hi_q, lo_q[W-1:1]};
                end
                if (cnt == CNT_LAST) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

`ifdef ALU_SEQ_DIV_EN
            ST_CHK: begin
                // OR with zero passes the divisor through so the ALU zero flag tests it.
                alu.alu_a    = '0;
                alu.alu_b    = lo_q;
                alu.alu_aluc = ALUC_OR;
                if (alu.alu_z) begin
                    dz_n    = 1'b1;
                    lo_n    = '1;
                    hi_n    = mcand;
                    state_n = ST_DONE;
                end else begin
                    // Swap so lo carries the dividend bits and mcand the divisor.
                    hi_n    = '0;
                    lo_n    = mcand;
                    mcand_n = lo_q;
                    state_n = ST_DIV;
                end
            end

            ST_DIV: begin
                rem_t        = {hi_q[W-2:0], lo_q[W-1]};
                alu.alu_a    = rem_t;
                alu.alu_b    = mcand;
                alu.alu_aluc = ALUC_SUB;
                // hi[31] set means the shifted remainder is really 33 bits wide and
                // therefore exceeds any 32-bit divisor; the truncated SUB is still exact.
                quo_bit = hi_q[W-1] | (rem_t >= mcand);
                hi_n    = quo_bit ? alu.alu_s : rem_t;
                lo_n    = {lo_q[W-2:0], quo_bit};
                if (cnt == CNT_LAST) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decoded status and result outputs
    // ------------------------------------------------------------------
    assign busy        = (state == ST_MUL) || (state == ST_CHK) || (state == ST_DIV);
    assign done        = (state == ST_DONE);
    assign alu.alu_own = busy;
    assign hi          = hi_q;
    assign lo          = lo_q;

`ifdef ALU_SEQ_DIV_EN
    assign dz = dz_q;
`else
    assign dz = 1'b0;
    // op and the zero flag only matter for division.
    logic unused_div_inputs;
    assign unused_div_inputs = &{1'b0, op, alu.alu_z};
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose : self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model.
// Latency : expected done latency is counted in clock edges after the accepting edge.
// Backpr. : none exercised beyond dropped start requests.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl_if #(.W(W)) aif ();

    // Shared single-cycle ALU as seen by the sequencer.
    function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            ALUC_ADD: return a + b;
            ALUC_SUB: return a - b;
            ALUC_OR:  return a | b;
            default:  return '0;
        endcase
    endfunction

    assign aif.alu_s = alu_f(aif.alu_aluc, aif.alu_a, aif.alu_b);
    assign aif.alu_z = (aif.alu_s == '0);

    alu_seq_ctrl #(.W(W), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .alu   (aif),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic. Latency is edges from the accepting edge to the
    // first sample showing done (spec: done in cycle k+33 / k+34 / k+2).
    task automatic ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                             output logic e_dz, output int e_lat);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        e_hi  = p[63:32];
        e_lo  = p[31:0];
        e_dz  = 1'b0;
        e_lat = 32;
`ifdef ALU_SEQ_DIV_EN
        if (o) begin
            if (b == '0) begin
                e_hi  = a;
                e_lo  = '1;
                e_dz  = 1'b1;
                e_lat = 1;
            end else begin
                e_hi  = a % b;
                e_lo  = a / b;
                e_lat = 33;
            end
        end
`else
        if (o) e_lat = 32;
`endif
    endtask

    // Launch one request and follow it to done. poke: sample index at which a
    // one-cycle stray start is driven; rst_at: sample index at which reset is pulsed.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, input int rst_at,
                          output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                          output logic r_dz, output int lat, output int own, output logic after_ok);
        r_hi = '0; r_lo = '0; r_dz = 1'b0; lat = -1; own = 0; after_ok = 1'b0;
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clock); #1;
        start = 1'b0;
        for (int m = 0; m <= 40; m++) begin
            if (m == rst_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                lat = -2;
                return;
            end
            if (done) begin
                lat = m; r_hi = hi; r_lo = lo; r_dz = dz;
                start = (m == poke);
                break;
            end
            if (aif.alu_own) own++;
            start = (m == poke);
            if (m == poke) begin
                op = ~o; opa = 32'd9; opb = 32'd9;
            end
            @(posedge clock); #1;
        end
        if (lat < 0) begin
            $display("FAIL timeout waiting for done op=%0d a=%0h b=%0h", o, a, b);
            errors++;
            checks++;
        end
        @(posedge clock); #1;
        start = 1'b0;
        after_ok = !done && !busy;
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] h, input logic [W-1:0] l, input logic d, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dz = d; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] r_hi, r_lo, e_hi, e_lo, ra, rb;
        logic         r_dz, e_dz, after_ok, ro;
        int           lat, own, e_lat;

        // Hand-derived vectors; latencies are edges after the accepting edge.
        add_vec(1'b0, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0, 32);
        add_vec(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
        add_vec(1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 32);
        add_vec(1'b0, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 32);
        add_vec(1'b0, 32'h80000000, 32'd2,        32'd1,        32'd0,        1'b0, 32);
`ifdef ALU_SEQ_DIV_EN
        add_vec(1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
        add_vec(1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33);
        add_vec(1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1);
        add_vec(1'b1, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0, 33);
        add_vec(1'b1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 33);
        add_vec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33);
`else
        add_vec(1'b1, 32'd5,        32'd0,        32'd0,        32'd0,        1'b0, 32);
        add_vec(1'b1, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 32);
`endif

        // Reset state
        reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_own",  64'(aif.alu_own), 64'd0);
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        check("rst_dz",   64'(dz), 64'd0);
        check("rst_alu_a", 64'(aif.alu_a), 64'd0);
        check("rst_alu_b", 64'(aif.alu_b), 64'd0);
        check("rst_aluc",  64'(aif.alu_aluc), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, r_hi, r_lo, r_dz, lat, own, after_ok);
            check($sformatf("vec%0d_hi", i),  64'(r_hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i),  64'(r_lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dz", i),  64'(r_dz), 64'(vecs[i].dz));
            check($sformatf("vec%0d_lat", i), 64'(lat),  64'(vecs[i].lat));
            check($sformatf("vec%0d_own", i), 64'(own),  64'(vecs[i].lat));
            check($sformatf("vec%0d_pulse", i), 64'(after_ok), 64'd1);
            // Results must hold in IDLE while the inputs wander.
            opa = $urandom; opb = $urandom; op = 1'(($urandom_range(0, 1)));
            repeat (2) @(posedge clock);
            #1;
            check($sformatf("vec%0d_hold_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_hold_lo", i), 64'(lo), 64'(vecs[i].lo));
        end

        // Stray start in the 10th MUL cycle of 3*4 is ignored.
        run_op(1'b0, 32'd3, 32'd4, 9, -1, r_hi, r_lo, r_dz, lat, own, after_ok);
        check("poke_mul_lo",  64'(r_lo), 64'd12);
        check("poke_mul_hi",  64'(r_hi), 64'd0);
        check("poke_mul_lat", 64'(lat),  64'd32);

        // Start during DONE is ignored: sequencer returns to IDLE and stays there.
        run_op(1'b0, 32'd7, 32'd6, 32, -1, r_hi, r_lo, r_dz, lat, own, after_ok);
        check("done_start_idle", 64'(after_ok), 64'd1);
        @(posedge clock); #1;
        check("done_start_busy", 64'(busy), 64'd0);
        check("done_start_lo",   64'(lo),   64'd42);

        // Reset in the 5th MUL cycle aborts with cleared results.
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 4, r_hi, r_lo, r_dz, lat, own, after_ok);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_own",  64'(aif.alu_own), 64'd0);
        check("abort_hi",   64'(hi), 64'd0);
        check("abort_lo",   64'(lo), 64'd0);
        run_op(1'b0, 32'd2, 32'd3, -1, -1, r_hi, r_lo, r_dz, lat, own, after_ok);
        check("recover_lo", 64'(r_lo), 64'd6);

        // Randomised requests against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ro = 1'(($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ref_model(ro, ra, rb, e_hi, e_lo, e_dz, e_lat);
            run_op(ro, ra, rb, -1, -1, r_hi, r_lo, r_dz, lat, own, after_ok);
            check($sformatf("rnd%0d_hi", i),  64'(r_hi), 64'(e_hi));
            check($sformatf("rnd%0d_lo", i),  64'(r_lo), 64'(e_lo));
            check($sformatf("rnd%0d_dz", i),  64'(r_dz), 64'(e_dz));
            check($sformatf("rnd%0d_lat", i), 64'(lat),  64'(e_lat));
            check($sformatf("rnd%0d_own", i), 64'(own),  64'(e_lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
